// File: rtl/glitch_sfifo.sv
// glitch_sfifo: single-clock FIFO for the glitch capture path.
// Build-time width, depth and read mode (standard or FWFT).
// Registered status flags, live fill level, and sticky error flags.
module glitch_sfifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 100,
   parameter int FWFT  = 0,
   localparam int AW   = $clog2(DEPTH + 1)
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DATA,
   input  logic             WE,
   input  logic             RE,
   input  logic [AW-1:0]    AFVAL,
   input  logic [AW-1:0]    AEVAL,
   input  logic             CLR_ERR,
   output logic [WIDTH-1:0] Q,
   output logic             FULL,
   output logic             EMPTY,
   output logic             AFULL,
   output logic             AEMPTY,
   output logic [AW-1:0]    LEVEL,
   output logic             OVERFLOW,
   output logic             UNDERFLOW
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [AW-1:0] LEVEL_MAX = AW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_nxt, rd_nxt;
   logic [AW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             afull_q, afull_d, aempty_q, aempty_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             wr_acc, rd_acc;

   // Acceptance uses the registered flags from before the edge.
   assign wr_acc = WE & ~full_q;
   assign rd_acc = RE & ~empty_q;

   // Next-state for pointers, level, flags, errors and the output word.
   always_comb begin
      wr_nxt    = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      rd_nxt    = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      wr_ptr_d  = wr_acc ? wr_nxt : wr_ptr_q;
      rd_ptr_d  = rd_acc ? rd_nxt : rd_ptr_q;
      level_d   = level_q;
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + AW'(1);
         2'b01:   level_d = level_q - AW'(1);
         default: level_d = level_q;
      endcase
      full_d    = (level_d == LEVEL_MAX);
      empty_d   = (level_d == '0);
      afull_d   = (level_d >= AFVAL);
      aempty_d  = (level_d <= AEVAL);
      // A fresh error on the clearing edge keeps the flag set.
      ovf_d     = (WE & full_q)  | (ovf_q & ~CLR_ERR);
      unf_d     = (RE & empty_q) | (unf_q & ~CLR_ERR);
      q_d       = q_q;
      if (FWFT != 0) begin
         // Q mirrors the post-edge head word. When the new head is the
         // slot being written this edge, take it straight from DATA.
         if (level_d != '0)
            q_d = (wr_acc && (rd_ptr_d == wr_ptr_q)) ? DATA : mem[rd_ptr_d];
      end else begin
         if (rd_acc)
            q_d = mem[rd_ptr_q];
      end
   end

   // Storage array; contents are intentionally not reset.
   always_ff @(posedge CLOCK) begin
      if (wr_acc)
         mem[wr_ptr_q] <= DATA;
   end

   // Control and status registers with asynchronous reset.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         q_q      <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         q_q      <= q_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign Q         = q_q;
   assign FULL      = full_q;
   assign EMPTY     = empty_q;
   assign AFULL     = afull_q;
   assign AEMPTY    = aempty_q;
   assign LEVEL     = level_q;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_glitch_sfifo.sv
// Directed bench for glitch_sfifo: standard 100-deep, standard 5-deep,
// and a 4-deep FWFT instance sharing one clock and reset.
module tb_glitch_sfifo;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLOCK = ~CLOCK;

   int nvec = 0;
   int nerr = 0;

   // 100-deep standard instance
   logic [31:0] d_s = '0, q_s;
   logic        we_s = 0, re_s = 0, clr_s = 0;
   logic [6:0]  af_s = 7'd99, ae_s = 7'd1, lvl_s;
   logic        full_s, empty_s, afull_s, aempty_s, ovf_s, unf_s;

   // 5-deep standard instance, AFVAL above DEPTH
   logic [31:0] d_5 = '0, q_5;
   logic        we_5 = 0, re_5 = 0, clr_5 = 0;
   logic [2:0]  af_5 = 3'd6, ae_5 = 3'd1, lvl_5;
   logic        full_5, empty_5, afull_5, aempty_5, ovf_5, unf_5;

   // 4-deep FWFT instance, AFVAL = AEVAL = 0
   logic [31:0] d_f = '0, q_f;
   logic        we_f = 0, re_f = 0, clr_f = 0;
   logic [2:0]  af_f = 3'd0, ae_f = 3'd0, lvl_f;
   logic        full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;

   glitch_sfifo #(.WIDTH(32), .DEPTH(100), .FWFT(0)) u_std (
      .CLOCK(CLOCK), .RESET(RESET), .DATA(d_s), .WE(we_s), .RE(re_s),
      .AFVAL(af_s), .AEVAL(ae_s), .CLR_ERR(clr_s), .Q(q_s),
      .FULL(full_s), .EMPTY(empty_s), .AFULL(afull_s), .AEMPTY(aempty_s),
      .LEVEL(lvl_s), .OVERFLOW(ovf_s), .UNDERFLOW(unf_s));

   glitch_sfifo #(.WIDTH(32), .DEPTH(5), .FWFT(0)) u_d5 (
      .CLOCK(CLOCK), .RESET(RESET), .DATA(d_5), .WE(we_5), .RE(re_5),
      .AFVAL(af_5), .AEVAL(ae_5), .CLR_ERR(clr_5), .Q(q_5),
      .FULL(full_5), .EMPTY(empty_5), .AFULL(afull_5), .AEMPTY(aempty_5),
      .LEVEL(lvl_5), .OVERFLOW(ovf_5), .UNDERFLOW(unf_5));

   glitch_sfifo #(.WIDTH(32), .DEPTH(4), .FWFT(1)) u_fw (
      .CLOCK(CLOCK), .RESET(RESET), .DATA(d_f), .WE(we_f), .RE(re_f),
      .AFVAL(af_f), .AEVAL(ae_f), .CLR_ERR(clr_f), .Q(q_f),
      .FULL(full_f), .EMPTY(empty_f), .AFULL(afull_f), .AEMPTY(aempty_f),
      .LEVEL(lvl_f), .OVERFLOW(ovf_f), .UNDERFLOW(unf_f));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      // reset state
      #1 RESET = 1'b1;
      #1;
      chk("rst_q", q_s, 0);        chk("rst_lvl", lvl_s, 0);
      chk("rst_empty", empty_s, 1); chk("rst_aempty", aempty_s, 1);
      chk("rst_full", full_s, 0);   chk("rst_afull", afull_s, 0);
      chk("rst_ovf", ovf_s, 0);     chk("rst_unf", unf_s, 0);
      chk("rst_fw_afull", afull_f, 0);
      #6 RESET = 1'b0;

      // idle edge: AFVAL=0 asserts AFULL, AFVAL=99 does not
      tick();
      chk("fw_afull0", afull_f, 1);
      chk("std_afull_idle", afull_s, 0);

      // ---------------- FWFT instance ----------------
      we_f = 1; d_f = 32'hA5A5A5A5; tick();
      chk("fw_empty_wr", empty_f, 0); chk("fw_q_wr", q_f, 32'hA5A5A5A5);
      chk("fw_lvl_wr", lvl_f, 1);     chk("fw_aempty_wr", aempty_f, 0);
      we_f = 0; re_f = 1; tick();
      chk("fw_empty_rd", empty_f, 1); chk("fw_q_hold", q_f, 32'hA5A5A5A5);
      re_f = 0; we_f = 1; d_f = 32'h11; tick();
      chk("fw_q_11", q_f, 32'h11);
      re_f = 1; d_f = 32'h22; tick();
      chk("fw_q_bypass", q_f, 32'h22); chk("fw_lvl_bypass", lvl_f, 1);
      re_f = 0; d_f = 32'h33; tick();
      chk("fw_q_head", q_f, 32'h22);   chk("fw_lvl2", lvl_f, 2);
      we_f = 0; re_f = 1; tick();
      chk("fw_q_33", q_f, 32'h33);     chk("fw_lvl1", lvl_f, 1);
      tick();
      chk("fw_empty2", empty_f, 1);    chk("fw_q_hold2", q_f, 32'h33);
      re_f = 0;

      // ---------------- 5-deep instance ----------------
      we_5 = 1;
      for (int i = 0; i < 5; i++) begin
         d_5 = i; tick();
      end
      we_5 = 0;
      chk("d5_full", full_5, 1); chk("d5_lvl5", lvl_5, 5);
      chk("d5_afull_never", afull_5, 0);
      re_5 = 1; tick(); chk("d5_q0", q_5, 0);
      tick();           chk("d5_q1", q_5, 1); chk("d5_lvl3", lvl_5, 3);
      we_5 = 1;
      for (int k = 0; k < 20; k++) begin
         d_5 = 5 + k; tick();
         chk("d5_wrap_q", q_5, 2 + k);
         chk("d5_wrap_lvl", lvl_5, 3);
      end
      we_5 = 0;
      for (int k = 0; k < 3; k++) begin
         tick(); chk("d5_drain_q", q_5, 22 + k);
      end
      chk("d5_empty", empty_5, 1);
      we_5 = 1; d_5 = 77; tick();
      chk("d5_coll_lvl", lvl_5, 1); chk("d5_coll_unf", unf_5, 1);
      chk("d5_coll_q", q_5, 24);
      we_5 = 0; tick();
      chk("d5_q77", q_5, 77); chk("d5_lvl0", lvl_5, 0);
      clr_5 = 1; tick();
      chk("d5_unf_clr_win", unf_5, 1);
      re_5 = 0; tick();
      chk("d5_unf_clr", unf_5, 0);
      clr_5 = 0;

      // ---------------- 100-deep instance: fill ----------------
      we_s = 1;
      for (int i = 0; i < 100; i++) begin
         d_s = i; tick();
         chk("fill_lvl", lvl_s, i + 1);
         chk("fill_aempty", aempty_s, (i + 1) <= 1);
         chk("fill_afull", afull_s, (i + 1) >= 99);
      end
      chk("fill_full", full_s, 1); chk("fill_ovf0", ovf_s, 0);
      d_s = 999; tick();
      chk("fill_ovf", ovf_s, 1); chk("fill_lvl_stay", lvl_s, 100);
      we_s = 0;

      // drain
      re_s = 1;
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("drain_q", q_s, i);
         chk("drain_lvl", lvl_s, 99 - i);
      end
      chk("drain_empty", empty_s, 1);
      tick();
      chk("drain_unf", unf_s, 1); chk("drain_q_hold", q_s, 99);
      re_s = 0; clr_s = 1; tick();
      chk("clr_ovf", ovf_s, 0); chk("clr_unf", unf_s, 0);
      clr_s = 0;

      // wrap-around with steady level 50
      we_s = 1;
      for (int i = 0; i < 50; i++) begin
         d_s = i; tick();
      end
      re_s = 1;
      for (int k = 0; k < 250; k++) begin
         d_s = 50 + k; tick();
         chk("wrap_q", q_s, k);
         chk("wrap_lvl", lvl_s, 50);
      end
      re_s = 0;
      for (int j = 0; j < 50; j++) begin
         d_s = 300 + j; tick();
      end
      chk("coll_full", full_s, 1);

      // boundary collision while FULL
      re_s = 1; d_s = 999; tick();
      chk("coll_full_lvl", lvl_s, 99); chk("coll_full_ovf", ovf_s, 1);
      chk("coll_full_q", q_s, 250);
      we_s = 0; re_s = 0; clr_s = 1; tick();
      chk("coll_ovf_clr", ovf_s, 0);
      clr_s = 0; we_s = 1; d_s = 351; tick();
      chk("coll_refull", full_s, 1);
      clr_s = 1; tick();
      chk("coll_ovf_clr_win", ovf_s, 1); chk("coll_lvl100", lvl_s, 100);
      clr_s = 0; we_s = 0;

      // drain to 37 then reset between edges
      re_s = 1;
      for (int i = 0; i < 63; i++) tick();
      re_s = 0;
      chk("pre_rst_lvl", lvl_s, 37); chk("pre_rst_q", q_s, 313);
      #2 RESET = 1'b1;
      #1;
      chk("mid_rst_lvl", lvl_s, 0);     chk("mid_rst_empty", empty_s, 1);
      chk("mid_rst_aempty", aempty_s, 1); chk("mid_rst_q", q_s, 0);
      chk("mid_rst_ovf", ovf_s, 0);
      #1 RESET = 1'b0;
      we_s = 1; d_s = 32'h1234; tick();
      chk("post_rst_lvl", lvl_s, 1);
      we_s = 0; re_s = 1; tick();
      chk("post_rst_q", q_s, 32'h1234); chk("post_rst_empty", empty_s, 1);
      re_s = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
